// File: rtl/block_buffer_arbiter.sv
// Round-robin arbiter sharing one BlockBuffer among NUM_REQ requesters, with in-order read-response
// routing. Optional per-requester accept counters: define BLOCK_BUFFER_ARBITER_STATS_EN.
package block_buffer_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] addr;
      logic [63:0] data;
      logic [2:0]  size;
   } ami_req_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } ami_resp_t;
endpackage

module block_buffer_arbiter
   import block_buffer_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned LOG_ORD_DEPTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  ami_req_t               req_in            [NUM_REQ],
   output logic                   req_grant_out     [NUM_REQ],
   output ami_resp_t              resp_out          [NUM_REQ],
   input  logic                   resp_grant_in     [NUM_REQ],
   output ami_req_t               bb_req_out,
   input  logic                   bb_req_grant_in,
   input  ami_resp_t              bb_resp_in,
   output logic                   bb_resp_grant_out,
   output logic [LOG_ORD_DEPTH:0] ord_count,
   output logic                   err_orphan
`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
   ,
   output logic [31:0]            stat_accept       [NUM_REQ]
`endif
);

   localparam int unsigned OrdDepth = 1 << LOG_ORD_DEPTH;
   localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IdxW-1:0]          rr_q, rr_d;
   logic [IdxW-1:0]          win, idx_c, head;
   logic                     found, accept, push, pop, empty, full;
   logic [NUM_REQ-1:0]       elig;
   logic [IdxW-1:0]          ord_mem_q [OrdDepth];
   logic [LOG_ORD_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOG_ORD_DEPTH:0]   cnt_q, cnt_d;
   logic                     err_q, err_d;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (LOG_ORD_DEPTH+1)'(OrdDepth));
   assign head  = ord_mem_q[rd_ptr_q];

   // Reads need a free order slot; writes never do.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_in[i].valid && (req_in[i].is_write || !full);
      end
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx_c = IdxW'((32'(rr_q) + k) % NUM_REQ);
         if (!found && elig[idx_c]) begin
            found = 1'b1;
            win   = idx_c;
         end
      end
   end

   assign accept = found && bb_req_grant_in && !rst;
   assign push   = accept && !req_in[win].is_write;
   assign pop    = !rst && !empty && bb_resp_in.valid && resp_grant_in[head];

   always_comb begin
      bb_req_out = '0;
      if (found && !rst) begin
         bb_req_out = req_in[win];
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_grant_out[i] = accept && (win == IdxW'(i));
         resp_out[i]      = '0;
         if (!rst && !empty && (head == IdxW'(i))) begin
            resp_out[i] = bb_resp_in;
         end
      end
   end

   assign bb_resp_grant_out = pop;
   assign ord_count         = cnt_q;
   assign err_orphan        = err_q;

   always_comb begin
      rr_d = rr_q;
      if (accept) begin
         rr_d = (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
      err_d = err_q | (bb_resp_in.valid && empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Entries are only read while counted valid, so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         ord_mem_q[wr_ptr_q] <= win;
      end
   end

`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
   logic [31:0] stat_q [NUM_REQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else if (accept && (stat_q[win] != 32'hFFFF_FFFF)) begin
         stat_q[win] <= stat_q[win] + 32'd1;
      end
   end

   assign stat_accept = stat_q;
`endif

endmodule

// File: tb/tb_block_buffer_arbiter.sv
// Self-checking bench for block_buffer_arbiter: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_block_buffer_arbiter;
   import block_buffer_arbiter_pkg::*;

   localparam int NR  = 4;
   localparam int DEP = 8;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   ami_req_t  req_in [NR];
   logic      req_grant_out [NR];
   ami_resp_t resp_out [NR];
   logic      resp_grant_in [NR];
   ami_req_t  bb_req_out;
   logic      bb_req_grant_in;
   ami_resp_t bb_resp_in;
   logic      bb_resp_grant_out;
   logic [3:0] ord_count;
   logic      err_orphan;
`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
   logic [31:0] stat_accept [NR];
`endif

   block_buffer_arbiter #(.NUM_REQ(NR), .LOG_ORD_DEPTH(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_in            (req_in),
      .req_grant_out     (req_grant_out),
      .resp_out          (resp_out),
      .resp_grant_in     (resp_grant_in),
      .bb_req_out        (bb_req_out),
      .bb_req_grant_in   (bb_req_grant_in),
      .bb_resp_in        (bb_resp_in),
      .bb_resp_grant_out (bb_resp_grant_out),
      .ord_count         (ord_count),
      .err_orphan        (err_orphan)
`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
      ,
      .stat_accept       (stat_accept)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: round-robin pointer, queue of outstanding read owners, sticky error.
   int          m_rr;
   int          m_q[$];
   bit          m_err;
   longint      m_stat [NR];
   bit          m_found;
   int          m_win;
   bit          n_acc, n_push, n_pop, n_orph;
   int          n_win;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int gidx();
      int g = -1;
      for (int i = 0; i < NR; i++) if (req_grant_out[i] === 1'b1) g = i;
      return g;
   endfunction

   function automatic void model_winner();
      m_found = 1'b0;
      m_win   = 0;
      for (int k = 0; k < NR; k++) begin
         int i = (m_rr + k) % NR;
         if (!m_found && req_in[i].valid && (req_in[i].is_write || m_q.size() < DEP)) begin
            m_found = 1'b1;
            m_win   = i;
         end
      end
   endfunction

   task automatic check_outputs();
      logic [NR-1:0] g_exp, g_obs;
      ami_req_t      r_exp;
      ami_resp_t     p_exp;
      bit            pop_exp;
      model_winner();
      g_exp = '0;
      r_exp = '0;
      if (m_found && !rst) r_exp = req_in[m_win];
      if (m_found && !rst && bb_req_grant_in) g_exp[m_win] = 1'b1;
      for (int i = 0; i < NR; i++) g_obs[i] = req_grant_out[i];
      chk("grant", 128'(g_obs), 128'(g_exp));
      chk("bb_req_out", 128'(bb_req_out), 128'(r_exp));
      for (int i = 0; i < NR; i++) begin
         p_exp = '0;
         if (!rst && m_q.size() > 0 && m_q[0] == i) p_exp = bb_resp_in;
         chk($sformatf("resp_out%0d", i), 128'(resp_out[i]), 128'(p_exp));
      end
      pop_exp = !rst && m_q.size() > 0 && bb_resp_in.valid && resp_grant_in[m_q[0]];
      chk("bb_resp_grant", 128'(bb_resp_grant_out), 128'(pop_exp));
      chk("ord_count", 128'(ord_count), 128'(m_q.size()));
      chk("err_orphan", 128'(err_orphan), 128'(m_err));
      n_acc  = m_found && bb_req_grant_in && !rst;
      n_win  = m_win;
      n_push = n_acc && !req_in[m_win].is_write;
      n_pop  = pop_exp;
      n_orph = !rst && bb_resp_in.valid && m_q.size() == 0;
   endtask

   task automatic cyc();
      check_outputs();
      @(posedge clk);
      #1;
      if (n_acc) begin
         m_rr = (n_win + 1) % NR;
         if (m_stat[n_win] < 64'hFFFF_FFFF) m_stat[n_win]++;
      end
      if (n_pop) void'(m_q.pop_front());
      if (n_push) m_q.push_back(n_win);
      if (n_orph) m_err = 1'b1;
   endtask

   task automatic go();
      #1;
      cyc();
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NR; i++) begin
         req_in[i]        = '0;
         resp_grant_in[i] = 1'b0;
      end
      bb_req_grant_in = 1'b0;
      bb_resp_in      = '0;
   endtask

   task automatic model_clear();
      m_rr  = 0;
      m_q.delete();
      m_err = 1'b0;
      for (int i = 0; i < NR; i++) m_stat[i] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      // Reset: requests present but nothing may be granted or routed.
      for (int i = 0; i < NR; i++) req_in[i] = '{valid: 1'b1, is_write: 1'b1, addr: 32'(i), data: 64'(i), size: 3'd3};
      bb_req_grant_in = 1'b1;
      bb_resp_in      = '{valid: 1'b1, data: 64'h55};
      do_reset();
      clear_inputs();

      // Continuous writes from all requesters rotate 0,1,2,3,0.
      for (int i = 0; i < NR; i++) req_in[i] = '{valid: 1'b1, is_write: 1'b1, addr: 32'(i*16), data: 64'(i), size: 3'd3};
      bb_req_grant_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("rr_order", 128'(gidx()), 128'(c % NR));
         cyc();
      end
      clear_inputs();
      bb_req_grant_in = 1'b1;

      // Two reads; responses come back in issue order.
      req_in[2] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h40, data: 64'h0, size: 3'd3};
      #1;
      chk("rd_grant2", 128'(gidx()), 128'(2));
      cyc();
      req_in[2] = '0;
      req_in[0] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h0, data: 64'h0, size: 3'd3};
      #1;
      chk("rd_grant0", 128'(gidx()), 128'(0));
      cyc();
      req_in[0] = '0;
      for (int i = 0; i < NR; i++) resp_grant_in[i] = 1'b1;
      bb_resp_in = '{valid: 1'b1, data: 64'hAAAA};
      #1;
      chk("resp_first", 128'(resp_out[2]), 128'({1'b1, 64'hAAAA}));
      cyc();
      bb_resp_in = '{valid: 1'b1, data: 64'hBBBB};
      #1;
      chk("resp_second", 128'(resp_out[0]), 128'({1'b1, 64'hBBBB}));
      cyc();
      bb_resp_in = '0;
      for (int i = 0; i < NR; i++) resp_grant_in[i] = 1'b0;

      // Nine reads from requester 1: the ninth is blocked, a write still passes.
      req_in[1] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h100, data: 64'h0, size: 3'd3};
      for (int c = 0; c < 9; c++) begin
         #1;
         chk("fill", 128'(gidx()), 128'((c < 8) ? 1 : -1));
         cyc();
      end
      chk("full_count", 128'(ord_count), 128'(8));
      req_in[3] = '{valid: 1'b1, is_write: 1'b1, addr: 32'h300, data: 64'h33, size: 3'd3};
      #1;
      chk("write_when_full", 128'(gidx()), 128'(3));
      cyc();
      req_in[3] = '0;
      req_in[1] = '0;

      // Response held while the head owner stalls.
      bb_resp_in = '{valid: 1'b1, data: 64'hCCCC};
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_grant", 128'(bb_resp_grant_out), 128'(0));
         chk("stall_count", 128'(ord_count), 128'(8));
         chk("stall_data", 128'(resp_out[1].data), 128'(64'hCCCC));
         cyc();
      end
      resp_grant_in[1] = 1'b1;
      for (int c = 0; c < 8; c++) go();
      bb_resp_in       = '0;
      resp_grant_in[1] = 1'b0;

      // Orphan response after reset.
      do_reset();
      bb_resp_in = '{valid: 1'b1, data: 64'hDEAD};
      #1;
      chk("orphan_pre", 128'(err_orphan), 128'(0));
      cyc();
      bb_resp_in = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("orphan_sticky", 128'(err_orphan), 128'(1));
         cyc();
      end

      // Asynchronous reset with three reads outstanding.
      do_reset();
      bb_req_grant_in = 1'b1;
      req_in[2] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h80, data: 64'h0, size: 3'd3};
      for (int c = 0; c < 3; c++) go();
      chk("pre_rst_count", 128'(ord_count), 128'(3));
      req_in[2] = '0;
      rst = 1'b1;
      model_clear();
      #1;
      chk("async_rst_count", 128'(ord_count), 128'(0));
      chk("async_rst_err", 128'(err_orphan), 128'(0));
      rst = 1'b0;
      for (int i = 0; i < NR; i++) req_in[i] = '{valid: 1'b1, is_write: 1'b1, addr: 32'(i), data: 64'(i), size: 3'd3};
      #1;
      chk("rr_after_rst", 128'(gidx()), 128'(0));
      cyc();
      clear_inputs();

      // 300 accepts by requester 0.
      do_reset();
      bb_req_grant_in = 1'b1;
      req_in[0] = '{valid: 1'b1, is_write: 1'b1, addr: 32'h0, data: 64'h1, size: 3'd3};
      for (int c = 0; c < 300; c++) go();
`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
      chk("stat_300", 128'(stat_accept[0]), 128'(300));
`endif
      clear_inputs();

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NR; i++) begin
            req_in[i].valid    = ($urandom % 3) != 0;
            req_in[i].is_write = ($urandom % 10) < 3;
            req_in[i].addr     = $urandom;
            req_in[i].data     = {$urandom, $urandom};
            req_in[i].size     = 3'($urandom);
            resp_grant_in[i]   = ($urandom % 3) != 0;
         end
         bb_req_grant_in  = ($urandom % 4) != 0;
         bb_resp_in.valid = (m_q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 50) == 0);
         bb_resp_in.data  = {$urandom, $urandom};
         go();
      end
`ifdef BLOCK_BUFFER_ARBITER_STATS_EN
      for (int i = 0; i < NR; i++) chk($sformatf("stat%0d", i), 128'(stat_accept[i]), 128'(m_stat[i]));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
